// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencer.
//  - pctrl_state_t : sequencer FSM states (encoding visible on ctrl_state).
//  - pctrl_rule_t  : RUN-state control rules, declared highest priority first.
//  - pctrl_ctl_t   : bundle of PC / latch enable and flush controls.
//  - rule_ctl()    : maps a resolved rule to its control bundle.
package pipeline_ctrl_pkg;

  localparam int unsigned PCTRL_REG_W = 5;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StDwait   = 2'd1,
    StHalting = 2'd2,
    StHalted  = 2'd3
  } pctrl_state_t;

  typedef enum logic [2:0] {
    RuleDmem    = 3'd0,
    RuleHalt    = 3'd1,
    RuleBranch  = 3'd2,
    RuleLoadUse = 3'd3,
    RuleImiss   = 3'd4,
    RuleRun     = 3'd5
  } pctrl_rule_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } pctrl_ctl_t;

  localparam pctrl_ctl_t CtlFreeze = 8'b0000_0000;
  localparam pctrl_ctl_t CtlReset  = 8'b0000_0111;

  function automatic pctrl_ctl_t rule_ctl(pctrl_rule_t rule);
    pctrl_ctl_t ctl;
    ctl = CtlFreeze;
    case (rule)
      RuleDmem:    ctl = CtlFreeze;
      // Let the halting instruction retire into MEM/WB, everything upstream stops.
      RuleHalt:    ctl = 8'b0000_1000;
      // Redirect PC and squash the three younger instructions.
      RuleBranch:  ctl = 8'b1111_1111;
      // Hold PC and IF/ID, inject a bubble into ID/EX.
      RuleLoadUse: ctl = 8'b0011_1010;
      // Fetch missed: keep PC, feed a bubble into IF/ID.
      RuleImiss:   ctl = 8'b0111_1100;
      RuleRun:     ctl = 8'b1111_1000;
      default:     ctl = CtlFreeze;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector (combinational).
//  idex_memread_i - instruction in EX is a load
//  idex_rd_i      - destination register of the EX instruction
//  ifid_rs_i/rt_i - source registers of the ID instruction
//  load_use_o     - ID consumes the load result one cycle too early
module pipeline_ctrl_hazard_detect #(
  parameter int unsigned REG_W = 5
) (
  input  logic             idex_memread_i,
  input  logic [REG_W-1:0] idex_rd_i,
  input  logic [REG_W-1:0] ifid_rs_i,
  input  logic [REG_W-1:0] ifid_rt_i,
  output logic             load_use_o
);

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use_o = idex_memread_i && (idex_rd_i != '0) &&
                      ((idex_rd_i == ifid_rs_i) || (idex_rd_i == ifid_rt_i));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage pipeline latches and PC.
// Configuration macro: PIPE_PERF_EN adds stall/flush performance counters.
// Ports:
//  CLK, RST          - clock, synchronous active-high reset
//  ihit, dhit        - instruction / data memory completion
//  dmemREN_mem/WEN   - load / store in MEM
//  halt_mem          - halt in MEM
//  br_taken_mem      - taken branch/jump resolved in MEM
//  idex_memread, idex_rd, ifid_rs, ifid_rt - load-use hazard inputs
//  pc_en, *_en, *_flush - PC and latch controls (flush wins over enable)
//  halt              - sticky halt
//  stall_cnt, flush_cnt - perf counters (PIPE_PERF_EN only)
//  ctrl_state        - current FSM state
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = PCTRL_REG_W
`ifdef PIPE_PERF_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemREN_mem,
  input  logic             dmemWEN_mem,
  input  logic             halt_mem,
  input  logic             br_taken_mem,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halt,
`ifdef PIPE_PERF_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic [1:0]       ctrl_state
);

  pctrl_state_t state_q, state_d;
  pctrl_rule_t  rule;
  pctrl_ctl_t   ctl;
  logic         halt_q, halt_d;
  logic         load_use;
  logic         dmem_block;

  pipeline_ctrl_hazard_detect #(
    .REG_W(REG_W)
  ) u_hazard_detect (
    .idex_memread_i(idex_memread),
    .idex_rd_i     (idex_rd),
    .ifid_rs_i     (ifid_rs),
    .ifid_rt_i     (ifid_rt),
    .load_use_o    (load_use)
  );

  // In DWAIT the access is already known outstanding, so only dhit releases the freeze.
  assign dmem_block = (state_q == StDwait) ? ~dhit
                                           : ((dmemREN_mem | dmemWEN_mem) & ~dhit);

  always_comb begin
    rule = RuleRun;
    if (dmem_block)        rule = RuleDmem;
    else if (halt_mem)     rule = RuleHalt;
    else if (br_taken_mem) rule = RuleBranch;
    else if (load_use)     rule = RuleLoadUse;
    else if (!ihit)        rule = RuleImiss;
  end

  always_comb begin
    ctl     = CtlFreeze;
    state_d = state_q;
    unique case (state_q)
      StRun, StDwait: begin
        ctl = rule_ctl(rule);
        case (rule)
          RuleDmem: state_d = StDwait;
          RuleHalt: state_d = StHalting;
          default:  state_d = StRun;
        endcase
      end
      StHalting: state_d = StHalted;
      StHalted:  state_d = StHalted;
    endcase
    if (RST) begin
      ctl     = CtlReset;
      state_d = StRun;
    end
  end

  assign halt_d = halt_q | (state_q == StHalting);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StRun;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  assign pc_en       = ctl.pc_en;
  assign ifid_en     = ctl.ifid_en;
  assign idex_en     = ctl.idex_en;
  assign exmem_en    = ctl.exmem_en;
  assign memwb_en    = ctl.memwb_en;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_flush  = ctl.idex_flush;
  assign exmem_flush = ctl.exmem_flush;
  // A stale halt_q must not show while reset is being applied.
  assign halt        = halt_q & ~RST;
  assign ctrl_state  = state_q;

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             cnt_active;

  // Counting stops once the halt sequence begins.
  assign cnt_active = (state_q == StRun) || (state_q == StDwait);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_active && !ctl.pc_en && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (cnt_active && (rule == RuleBranch) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus a randomized run
// against a rule-level reference model.
module tb_pipeline_ctrl;

  localparam int unsigned REG_W = 5;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic             RST, ihit, dhit, dmemREN_mem, dmemWEN_mem, halt_mem, br_taken_mem;
  logic             idex_memread;
  logic [REG_W-1:0] idex_rd, ifid_rs, ifid_rt;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush, halt;
  logic [1:0]       ctrl_state;
  logic [7:0]       ctl;

  assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush};

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic [1:0]  stall_cnt2, flush_cnt2;
  logic pc_en2, ifid_en2, idex_en2, exmem_en2, memwb_en2;
  logic ifid_flush2, idex_flush2, exmem_flush2, halt2;
  logic [1:0] ctrl_state2;
`endif

  pipeline_ctrl #(
    .REG_W(REG_W)
  ) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .dmemREN_mem(dmemREN_mem), .dmemWEN_mem(dmemWEN_mem), .halt_mem(halt_mem),
    .br_taken_mem(br_taken_mem), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .halt(halt),
`ifdef PIPE_PERF_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .ctrl_state(ctrl_state)
  );

`ifdef PIPE_PERF_EN
  pipeline_ctrl #(
    .REG_W(REG_W),
    .CNT_W(2)
  ) dut_small (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .dmemREN_mem(dmemREN_mem), .dmemWEN_mem(dmemWEN_mem), .halt_mem(halt_mem),
    .br_taken_mem(br_taken_mem), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .pc_en(pc_en2), .ifid_en(ifid_en2),
    .idex_en(idex_en2), .exmem_en(exmem_en2), .memwb_en(memwb_en2),
    .ifid_flush(ifid_flush2), .idex_flush(idex_flush2), .exmem_flush(exmem_flush2),
    .halt(halt2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2),
    .ctrl_state(ctrl_state2)
  );
`endif

  int checks = 0;
  int errors = 0;

  // Control patterns in {pc, ifid_en, idex_en, exmem_en, memwb_en, ifid_f, idex_f, exmem_f}.
  localparam logic [7:0] P_RESET  = 8'b0000_0111;
  localparam logic [7:0] P_FREEZE = 8'b0000_0000;
  localparam logic [7:0] P_RUN    = 8'b1111_1000;
  localparam logic [7:0] P_BRANCH = 8'b1111_1111;
  localparam logic [7:0] P_HALT   = 8'b0000_1000;

  // Reference model state: 0 run, 1 waiting on dmem, 2 halting, 3 halted.
  int          m_state;
  longint      m_stall, m_flush;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    ihit = 1'b1; dhit = 1'b0; dmemREN_mem = 1'b0; dmemWEN_mem = 1'b0;
    halt_mem = 1'b0; br_taken_mem = 1'b0; idex_memread = 1'b0;
    idex_rd = '0; ifid_rs = '0; ifid_rt = '0;
  endtask

  // Expected controls for the current inputs; en bits whose latch is flushed are
  // masked out of 'care' where the rule leaves them open.
  task automatic model(output logic [7:0] exp, output logic [7:0] care, output int nxt,
                       output bit stall, output bit flush);
    bit wait_mem, lu;
    care = 8'hFF; stall = 0; flush = 0; nxt = m_state;
    if (RST) begin
      exp = P_RESET; nxt = 0;
    end else if (m_state >= 2) begin
      exp = P_FREEZE; nxt = 3;
    end else begin
      wait_mem = (m_state == 1) ? !dhit : ((dmemREN_mem || dmemWEN_mem) && !dhit);
      lu = idex_memread && (idex_rd != 0) && (idex_rd == ifid_rs || idex_rd == ifid_rt);
      nxt = 0;
      if (wait_mem) begin
        exp = P_FREEZE; nxt = 1;
      end else if (halt_mem) begin
        exp = P_HALT; nxt = 2;
      end else if (br_taken_mem) begin
        exp = P_BRANCH; flush = 1;
      end else if (lu) begin
        exp = 8'b0001_1010; care = 8'b1101_1111;
      end else if (!ihit) begin
        exp = 8'b0011_1100; care = 8'b1011_1111;
      end else begin
        exp = P_RUN;
      end
      stall = !exp[7];
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    ihit = 1; dhit = 1; dmemREN_mem = 1; dmemWEN_mem = 1; halt_mem = 1; br_taken_mem = 1;
    idex_memread = 1; idex_rd = '1; ifid_rs = '1; ifid_rt = '1;
    #1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (ctl !== P_RESET) begin
        errors++; $display("FAIL reset_ctl cycle %0d: got %b want %b", c, ctl, P_RESET);
      end
      checks++;
      if (halt !== 1'b0) begin
        errors++; $display("FAIL reset_halt cycle %0d: got %b want 0", c, halt);
      end
    end
    RST = 1'b0;
    set_idle();
    tick();
    checks++;
    if (ctrl_state !== 2'd0 || ctl !== P_RUN) begin
      errors++; $display("FAIL reset_release: state %0d ctl %b want 0 %b", ctrl_state, ctl, P_RUN);
    end
  endtask

  task automatic test_dwait();
    set_idle();
    dmemREN_mem = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++;
      if (ctl !== P_FREEZE) begin
        errors++; $display("FAIL dwait_freeze cycle %0d: got %b want %b", c, ctl, P_FREEZE);
      end
      if (c > 0) begin
        checks++;
        if (ctrl_state !== 2'd1) begin
          errors++; $display("FAIL dwait_state cycle %0d: got %0d want 1", c, ctrl_state);
        end
      end
      tick();
    end
    dhit = 1'b1;
    #2;
    checks++;
    if (ctl !== P_RUN) begin
      errors++; $display("FAIL dwait_release: got %b want %b", ctl, P_RUN);
    end
    tick();
    set_idle();
    #2;
    checks++;
    if (ctrl_state !== 2'd0) begin
      errors++; $display("FAIL dwait_exit_state: got %0d want 0", ctrl_state);
    end
    tick();
  endtask

  task automatic test_load_use();
    set_idle();
    idex_memread = 1; idex_rd = 5'd8; ifid_rt = 5'd8; ifid_rs = 5'd3;
    #2;
    checks++;
    if (pc_en !== 0 || ifid_en !== 0 || idex_flush !== 1 || exmem_en !== 1 || memwb_en !== 1
        || ifid_flush !== 0 || exmem_flush !== 0) begin
      errors++; $display("FAIL load_use_rt: got %b want 00x11010", ctl);
    end
    ifid_rt = 5'd2; ifid_rs = 5'd8; ihit = 0;
    #1;
    checks++;
    if (pc_en !== 0 || ifid_en !== 0 || ifid_flush !== 0 || idex_flush !== 1) begin
      errors++; $display("FAIL load_use_over_imiss: got %b want 00x11010", ctl);
    end
    idex_rd = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; ihit = 1;
    #1;
    checks++;
    if (ctl !== P_RUN) begin
      errors++; $display("FAIL load_use_r0: got %b want %b", ctl, P_RUN);
    end
    tick();
  endtask

  task automatic test_branch();
    set_idle();
    br_taken_mem = 1; ihit = 0;
    #2;
    checks++;
    if (ctl !== P_BRANCH) begin
      errors++; $display("FAIL branch_imiss: got %b want %b", ctl, P_BRANCH);
    end
    idex_memread = 1; idex_rd = 5'd4; ifid_rs = 5'd4;
    #1;
    checks++;
    if (ctl !== P_BRANCH) begin
      errors++; $display("FAIL branch_over_load_use: got %b want %b", ctl, P_BRANCH);
    end
    tick();
    set_idle();
  endtask

  task automatic test_halt();
    set_idle();
    halt_mem = 1;
    #2;
    checks++;
    if (ctl !== P_HALT) begin
      errors++; $display("FAIL halt_retire: got %b want %b", ctl, P_HALT);
    end
    tick();
    halt_mem = 0;
    #2;
    checks++;
    if (ctrl_state !== 2'd2 || ctl !== P_FREEZE || halt !== 0) begin
      errors++; $display("FAIL halting: state %0d ctl %b halt %b want 2 0 0", ctrl_state, ctl, halt);
    end
    tick();
    for (int c = 0; c < 20; c++) begin
      ihit = c[0]; dhit = ~c[0]; br_taken_mem = c[1]; halt_mem = c[2];
      #2;
      checks++;
      if (halt !== 1 || ctl !== P_FREEZE || ctrl_state !== 2'd3) begin
        errors++;
        $display("FAIL halted cycle %0d: halt %b ctl %b state %0d want 1 0 3", c, halt, ctl,
                 ctrl_state);
      end
      tick();
    end
    RST = 1;
    #1;
    checks++;
    if (halt !== 0 || ctl !== P_RESET) begin
      errors++; $display("FAIL halt_reset: halt %b ctl %b want 0 %b", halt, ctl, P_RESET);
    end
    tick();
    RST = 0;
    set_idle();
    #1;
    checks++;
    if (halt !== 0 || ctrl_state !== 2'd0) begin
      errors++; $display("FAIL halt_cleared: halt %b state %0d want 0 0", halt, ctrl_state);
    end
    tick();
  endtask

  task automatic test_random();
    logic [7:0] exp, care;
    int nxt;
    bit st, fl;
    RST = 1; set_idle();
    tick();
    RST = 0;
    m_state = 0; m_stall = 0; m_flush = 0;
    for (int i = 0; i < 600; i++) begin
      RST          = ($urandom_range(0, 49) == 0);
      ihit         = ($urandom_range(0, 3) != 0);
      dhit         = ($urandom_range(0, 2) == 0);
      dmemREN_mem  = ($urandom_range(0, 5) == 0);
      dmemWEN_mem  = ($urandom_range(0, 7) == 0);
      halt_mem     = ($urandom_range(0, 39) == 0);
      br_taken_mem = ($urandom_range(0, 6) == 0);
      idex_memread = ($urandom_range(0, 1) == 0);
      idex_rd      = REG_W'($urandom_range(0, 3));
      ifid_rs      = REG_W'($urandom_range(0, 3));
      ifid_rt      = REG_W'($urandom_range(0, 3));
      #2;
      model(exp, care, nxt, st, fl);
      checks++;
      if ((ctl & care) !== (exp & care)) begin
        errors++;
        $display("FAIL rand_ctl iter %0d state %0d: got %b want %b (care %b)", i, m_state, ctl,
                 exp, care);
      end
      checks++;
      if (ctrl_state !== m_state[1:0] || halt !== (!RST && m_state == 3)) begin
        errors++;
        $display("FAIL rand_state iter %0d: state %0d halt %b want %0d %b", i, ctrl_state, halt,
                 m_state, (!RST && m_state == 3));
      end
`ifdef PIPE_PERF_EN
      checks++;
      if (stall_cnt !== m_stall[31:0] || flush_cnt !== m_flush[31:0]) begin
        errors++;
        $display("FAIL rand_perf iter %0d: stall %0d flush %0d want %0d %0d", i, stall_cnt,
                 flush_cnt, m_stall, m_flush);
      end
      if (RST) begin
        m_stall = 0; m_flush = 0;
      end else begin
        m_stall += st; m_flush += fl;
      end
`endif
      m_state = nxt;
      tick();
    end
    RST = 1; set_idle();
    tick();
    RST = 0;
  endtask

`ifdef PIPE_PERF_EN
  task automatic test_perf();
    RST = 1; set_idle();
    tick();
    RST = 0;
    idex_memread = 1; idex_rd = 5'd9; ifid_rs = 5'd9;
    for (int c = 0; c < 5; c++) tick();
    set_idle();
    br_taken_mem = 1;
    for (int c = 0; c < 2; c++) tick();
    set_idle();
    #1;
    checks++;
    if (stall_cnt !== 32'd5 || flush_cnt !== 32'd2) begin
      errors++; $display("FAIL perf_counts: stall %0d flush %0d want 5 2", stall_cnt, flush_cnt);
    end
    checks++;
    if (flush_cnt2 !== 2'd2) begin
      errors++; $display("FAIL perf_small_flush: got %0d want 2", flush_cnt2);
    end
    idex_memread = 1; idex_rd = 5'd9; ifid_rt = 5'd9;
    tick();
    set_idle();
    #1;
    checks++;
    if (stall_cnt2 !== 2'd3 || stall_cnt !== 32'd6) begin
      errors++; $display("FAIL perf_saturate: small %0d wide %0d want 3 6", stall_cnt2, stall_cnt);
    end
    tick();
  endtask
`endif

  initial begin
    set_idle();
    test_reset();
    test_dwait();
    test_load_use();
    test_branch();
    test_halt();
    test_random();
`ifdef PIPE_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
